// File: rtl/router_pkg.sv
// Shared router constants: datapath widths, FIFO geometry and header field positions.
package router_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned FIFO_DEPTH   = 16;
  localparam int unsigned FIFO_ADDR_W  = 4;
  localparam int unsigned HDR_FLAG_BIT = DATA_W;

  localparam int unsigned LEN_MSB  = 7;
  localparam int unsigned LEN_LSB  = 2;
  localparam int unsigned ADDR_MSB = 1;
  localparam int unsigned ADDR_LSB = 0;

  localparam int unsigned CNT_W = 7;

  // Bytes still to read after a header: payload length plus the parity byte.
  function automatic logic [CNT_W-1:0] pkt_count(input logic [DATA_W-1:0] hdr);
    return CNT_W'(hdr[LEN_MSB:LEN_LSB]) + CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Dual-port register array: synchronous write, clear-all on reset, combinational read.
module router_fifo_mem
  import router_pkg::*;
#(
  parameter int unsigned WORD_W = DATA_W + 1,
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WORD_W-1:0] rd_data_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Storage update: hard reset clears every entry, otherwise write on request.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/router_out_fifo.sv
// Per-output-port packet FIFO: header-flagged storage, read-side packet byte counter,
// hard reset clears storage, soft_reset flushes pointers while keeping memory contents.
module router_out_fifo
  import router_pkg::*;
#(
  parameter int unsigned DATA_W = router_pkg::DATA_W,
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic [DATA_W:0]    rd_word;
  logic               do_write, do_read;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  // A flush discards any read or write presented in the same cycle.
  assign do_write = write_enb && !full  && !soft_reset;
  assign do_read  = read_enb  && !empty && !soft_reset;

  router_fifo_mem #(
    .WORD_W (DATA_W + 1),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock     (clock),
    .resetn    (resetn),
    .wr_en_i   (do_write),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i ({lfd_state, data_in}),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (rd_word)
  );

  // Next-state for pointers, packet counter and registered read data.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    if (soft_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      dout_d   = '0;
    end else begin
      if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_read) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        dout_d   = rd_word[DATA_W-1:0];
        if (rd_word[DATA_W])
          cnt_d = pkt_count(rd_word[7:0]);
        else if (cnt_q != '0)
          cnt_d = cnt_q - 1'b1;
      end else if (cnt_q == '0) begin
        dout_d = '0;
      end
    end
  end

  // State registers with hard reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end

  assign data_out = dout_q;

endmodule
